rv32_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core. It holds the program counter, issues word reads to instruction memory through a request/grant/response handshake, and buffers the returned words in a small in-order queue. It presents one instruction at a time, with its PC, to the decode/control stage. Taken branches and jumps, signalled by PCSel, redirect fetch to the ALU-computed target and discard all wrong-path words.

---
 rtl/rv32_fetch_unit.sv | 133 +++++++++++++
 tb/tb_rv32_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_fetch_unit.sv
// RV32I instruction fetch stage: owns the fetch PC, issues in-order word reads,
// buffers returned instructions and redirects on taken branches/jumps.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    input  logic        i_inst_ready,
    input  logic        i_pc_sel,
    input  logic [31:0] i_alu_target
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {BOOT, FETCH} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_cnt;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          inst_valid;
    logic          consume;
    logic          redirect;
    logic          gnt_fire;
    logic          push;
    logic [31:0]   target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign inst_valid = (buf_cnt != '0);
    assign consume    = inst_valid && i_inst_ready;
    assign redirect   = consume && i_pc_sel;
    assign target     = i_alu_target & 32'hFFFF_FFFC;

    // Credit only registered occupancy so the request never depends on a same-cycle pop.
    assign o_imem_req  = (state == FETCH) && ((int'(buf_cnt) + int'(out_cnt)) < DEPTH);
    assign o_imem_addr = fetch_pc;
    assign gnt_fire    = o_imem_req && i_imem_gnt;

    // A response landing in the redirect cycle is wrong-path by definition.
    assign push = i_imem_rvalid && (drop_cnt == '0) && !redirect;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        out_next = out_cnt;
        if (gnt_fire && !i_imem_rvalid) begin
            out_next = out_cnt + CW'(1);
        end else if (!gnt_fire && i_imem_rvalid) begin
            out_next = out_cnt - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            buf_cnt  <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            state   <= FETCH;
            out_cnt <= out_next;
            if (redirect) begin
                // Everything still in flight, including this cycle's grant, is stale.
                fetch_pc <= target;
                resp_pc  <= target;
                drop_cnt <= out_next;
                buf_cnt  <= '0;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (gnt_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (i_imem_rvalid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    tail    <= ptr_inc(tail);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (consume) begin
                    head <= ptr_inc(head);
                end
                case ({push, consume})
                    2'b10:   buf_cnt <= buf_cnt + CW'(1);
                    2'b01:   buf_cnt <= buf_cnt - CW'(1);
                    default: buf_cnt <= buf_cnt;
                endcase
            end
        end
    end

    // NOTE: buffer storage has no reset; buf_cnt alone decides validity and the outputs mux it off when empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            inst_mem[tail] <= i_imem_rdata;
            pc_mem[tail]   <= resp_pc;
        end
    end

    assign o_inst_valid  = inst_valid;
    assign o_instruction = inst_valid ? inst_mem[head] : NOP_INST;
    assign o_pc          = inst_valid ? pc_mem[head] : resp_pc;
    assign o_pc_plus4    = o_pc + 32'd4;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Self-checking bench for rv32_fetch_unit: in-order memory model with variable
// latency and a scoreboard of expected PCs popped as instructions are consumed.
module tb_rv32_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        i_inst_ready;
    logic        i_pc_sel;
    logic [31:0] i_alu_target;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;

    rd_t         pend[$];
    logic [31:0] fire_addrs[$];
    logic [31:0] exp_pc[$];
    int          cyc;
    int          lat;
    int          n_fire;
    logic [31:0] key;
    int          n_tests;
    int          n_fail;

    rv32_fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH),
        .NOP_INST(NOP_INST)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_gnt   (i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata (i_imem_rdata),
        .o_inst_valid (o_inst_valid),
        .o_instruction(o_instruction),
        .o_pc         (o_pc),
        .o_pc_plus4   (o_pc_plus4),
        .i_inst_ready (i_inst_ready),
        .i_pc_sel     (i_pc_sel),
        .i_alu_target (i_alu_target)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ key;
    endfunction

    // Transfers are decided mid-cycle, when req/gnt are settled.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                pend.delete();
            end else begin
                if (i_imem_rvalid && pend.size() > 0) pend.delete(0);
                if (o_imem_req && i_imem_gnt) begin
                    pend.push_back('{o_imem_addr, cyc + lat});
                    fire_addrs.push_back(o_imem_addr);
                    n_fire++;
                end
            end
        end
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge i_clk);
            cyc++;
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = mem_data(pend[0].addr);
            end else begin
                i_imem_rvalid = 1'b0;
                i_imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic hold_reset();
        i_rst_n       = 1'b0;
        i_inst_ready  = 1'b0;
        i_pc_sel      = 1'b0;
        i_imem_rvalid = 1'b0;
        pend.delete();
        exp_pc.delete();
        fire_addrs.delete();
        n_fire = 0;
        lat    = 1;
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic check_head();
        logic [31:0] e;
        if (exp_pc.size() == 0) begin
            check("sb_underflow", 32'(exp_pc.size()), 32'd1);
        end else begin
            e = exp_pc.pop_front();
            check("pc", o_pc, e);
            check("inst", o_instruction, mem_data(e));
            check("pc_plus4", o_pc_plus4, e + 32'd4);
        end
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!o_inst_valid && waited < 100) begin
            step();
            waited++;
        end
        check("valid_timeout", 32'(o_inst_valid), 32'd1);
    endtask

    task automatic stream(input int n, output int cycles);
        int got;
        got    = 0;
        cycles = 0;
        i_inst_ready = 1'b1;
        while (got < n && cycles < 200) begin
            if (o_inst_valid) begin
                check_head();
                got++;
            end
            step();
            cycles++;
        end
        i_inst_ready = 1'b0;
        check("stream_count", 32'(got), 32'(n));
    endtask

    task automatic consume_one();
        int w;
        wait_valid(w);
        check_head();
        i_inst_ready = 1'b1;
        step();
        i_inst_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        int w;
        wait_valid(w);
        check_head();
        i_inst_ready = 1'b1;
        i_pc_sel     = 1'b1;
        i_alu_target = tgt;
        step();
        i_inst_ready = 1'b0;
        i_pc_sel     = 1'b0;
        i_alu_target = $urandom;
    endtask

    task automatic check_fire(input int idx, input logic [31:0] exp);
        for (int k = 0; k < 50 && fire_addrs.size() <= idx; k++) step();
        check("fire_addr", (fire_addrs.size() > idx) ? fire_addrs[idx] : 32'hxxxx_xxxx, exp);
    endtask

    initial begin
        int c;
        n_tests      = 0;
        n_fail       = 0;
        key          = 32'h0;
        i_imem_gnt   = 1'b1;
        i_alu_target = 32'h0;
        i_imem_rdata = 32'h0;
        hold_reset();

        // Reset values
        #12;
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_addr", o_imem_addr, RESET_PC);
        check("rst_valid", 32'(o_inst_valid), 32'd0);
        check("rst_inst", o_instruction, NOP_INST);
        check("rst_pc", o_pc, RESET_PC);
        check("rst_pc_plus4", o_pc_plus4, RESET_PC + 32'd4);

        // Boot: first request one cycle after release, first instruction on cycle 3
        release_reset();
        check("boot_req", 32'(o_imem_req), 32'd1);
        check("boot_addr", o_imem_addr, RESET_PC);
        check("boot_valid_c1", 32'(o_inst_valid), 32'd0);
        step();
        check("boot_valid_c2", 32'(o_inst_valid), 32'd0);
        step();
        check("boot_valid_c3", 32'(o_inst_valid), 32'd1);
        for (int i = 0; i < 8; i++) exp_pc.push_back(RESET_PC + 32'(4 * i));
        stream(8, c);
        check("stream_rate", 32'(c), 32'd8);

        // Stall: exactly DEPTH requests, then a stable head and in-order drain
        hold_reset();
        key = 32'h5A5A_0000;
        release_reset();
        repeat (11) step();
        check("stall_fires", 32'(n_fire), 32'(DEPTH));
        check("stall_req", 32'(o_imem_req), 32'd0);
        check("stall_valid", 32'(o_inst_valid), 32'd1);
        check("stall_head_pc", o_pc, RESET_PC);
        check("stall_head_inst", o_instruction, mem_data(RESET_PC));
        for (int i = 0; i < 11; i++) exp_pc.push_back(RESET_PC + 32'(4 * i));
        stream(11, c);

        // Redirect at pc 8 with two slow reads outstanding
        hold_reset();
        release_reset();
        repeat (8) step();
        lat = 6;
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        exp_pc.push_back(32'h8);
        consume_one();
        consume_one();
        step();
        check("pre_redirect_req", 32'(o_imem_req), 32'd0);
        redirect(32'h0000_0103);
        fire_addrs.delete();
        lat = 1;
        check_fire(0, 32'h0000_0100);
        exp_pc.push_back(32'h100);
        exp_pc.push_back(32'h104);
        stream(2, c);

        // Redirect coinciding with a grant and a response
        repeat (6) step();
        for (int i = 0; i < 6; i++) exp_pc.push_back(32'h108 + 32'(4 * i));
        stream(5, c);
        check("coincide_req", 32'(o_imem_req), 32'd1);
        redirect(32'h0000_2000);
        wait_valid(c);
        check("redirect_penalty", 32'(c), 32'd2);
        for (int i = 0; i < 3; i++) exp_pc.push_back(32'h2000 + 32'(4 * i));
        stream(3, c);

        // Address wrap at the top of memory; low target bits are dropped
        exp_pc.push_back(32'h200C);
        redirect(32'hFFFF_FFFF);
        fire_addrs.delete();
        exp_pc.push_back(32'hFFFF_FFFC);
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        stream(3, c);
        check_fire(0, 32'hFFFF_FFFC);
        check_fire(1, 32'h0000_0000);

        // Async reset pulse with two words buffered
        hold_reset();
        release_reset();
        repeat (3) step();
        check("pulse_pre_valid", 32'(o_inst_valid), 32'd1);
        #1;
        hold_reset();
        #1;
        check("pulse_valid", 32'(o_inst_valid), 32'd0);
        check("pulse_req", 32'(o_imem_req), 32'd0);
        check("pulse_inst", o_instruction, NOP_INST);
        check("pulse_addr", o_imem_addr, RESET_PC);
        release_reset();
        for (int i = 0; i < 3; i++) exp_pc.push_back(RESET_PC + 32'(4 * i));
        stream(3, c);
        check_fire(0, RESET_PC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
